// File: rtl/atpg_pkg.sv
// Shared types and constants for the pseudo-random pattern BIST engine.
package atpg_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_APPLY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  // Polynomial x^233 + x^74 + 1 for the pattern generator.
  localparam int LFSR_TAP  = 74;
  localparam int MISR_TAP  = 37;
  localparam int DEF_IN_W  = 233;
  localparam int DEF_OUT_W = 140;

endpackage

// File: rtl/atpg_lfsr_misr.sv
// Pattern-generating LFSR and response-compacting MISR with their step functions.
module atpg_lfsr_misr
  import atpg_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lfsr_load,
  input  logic [IN_W-1:0]  lfsr_seed,
  input  logic             lfsr_step,
  input  logic             misr_clear,
  input  logic             misr_update,
  input  logic [OUT_W-1:0] misr_in,
  output logic [IN_W-1:0]  lfsr_d,
  output logic [OUT_W-1:0] misr_q,
  output logic [OUT_W-1:0] misr_d
);

  logic [IN_W-1:0] lfsr_q;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_load)
      lfsr_d = (lfsr_seed == '0) ? IN_W'(1) : lfsr_seed;
    else if (lfsr_step)
      lfsr_d = {lfsr_q[IN_W-2:0], lfsr_q[IN_W-1] ^ lfsr_q[LFSR_TAP-1]};
  end

  always_comb begin
    misr_d = misr_q;
    if (misr_clear)
      misr_d = '0;
    else if (misr_update)
      misr_d = {misr_q[OUT_W-2:0], misr_q[OUT_W-1] ^ misr_q[MISR_TAP-1]} ^ misr_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '0;
      misr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
    end
  end

endmodule

// File: rtl/atpg_bist_engine.sv
// BIST run controller: applies N LFSR patterns to the CUT, compacts responses
// into a MISR and compares the final signature with a golden value.
module atpg_bist_engine
  import atpg_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [IN_W-1:0]  seed,
  input  logic [OUT_W-1:0] golden_sig,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic             pass,
  output state_t           dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE; busy is high
  // from LOAD through the last CAPTURE, and done pulses for the single FINISH cycle.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, cnt_q;
  logic [IN_W-1:0]  seed_q, cut_in_q, lfsr_d;
  logic [OUT_W-1:0] misr_q, misr_d;
  logic             pass_q, accept, last_pat, do_load, do_capture;

  assign accept   = (state_q == S_IDLE) && start;
  assign last_pat = (cnt_q == n_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD:    state_d = (n_q == '0) ? S_FINISH : S_APPLY;
      S_APPLY:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_pat ? S_FINISH : S_APPLY;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    do_load    = 1'b0;
    do_capture = 1'b0;
    case (state_q)
      S_LOAD:    begin busy = 1'b1; do_load = 1'b1; end
      S_APPLY:   busy = 1'b1;
      S_CAPTURE: begin busy = 1'b1; do_capture = 1'b1; end
      S_FINISH:  done = 1'b1;
      default:   ;
    endcase
  end

  // cut_in only changes when entering APPLY, so it is stable through CAPTURE,
  // FINISH and IDLE. pass is judged from the MISR value FINISH will show.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      seed_q   <= '0;
      cnt_q    <= '0;
      cut_in_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      if (accept) begin
        n_q    <= num_patterns;
        seed_q <= seed;
        pass_q <= 1'b0;
      end
      if (do_load)    cnt_q <= '0;
      if (do_capture) cnt_q <= cnt_q + CNT_W'(1);
      if (state_d == S_APPLY)  cut_in_q <= lfsr_d;
      if (state_d == S_FINISH) pass_q   <= (misr_d == golden_sig);
    end
  end

  atpg_lfsr_misr #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lfsr_misr (
    .clk         (clk),
    .rst         (rst),
    .lfsr_load   (do_load),
    .lfsr_seed   (seed_q),
    .lfsr_step   (do_capture),
    .misr_clear  (do_load),
    .misr_update (do_capture),
    .misr_in     (cut_out),
    .lfsr_d      (lfsr_d),
    .misr_q      (misr_q),
    .misr_d      (misr_d)
  );

  assign cut_in    = cut_in_q;
  assign signature = misr_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule
